// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, data width and
// the baud divider calculation used by both link directions.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // Rounded clock divider for one oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, restartable
// through a synchronous clear so the receiver can phase-align to a start edge.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// Oversampling UART byte receiver with valid/ready output. Frame is 8N1 by
// default, 8E1 when UART_PARITY_EN is defined.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  rx_state_e  state;
  logic       sync1, sync2, rxd_prev;
  logic       tick;
  logic [TW-1:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       start_edge;
  logic       stop_sample;
  logic       par_bad;
  logic       deliver;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      sync2    <= sync1;
      rxd_prev <= sync2;
    end
  end

  assign start_edge  = (state == IDLE) && rxd_prev && !sync2;
  assign stop_sample = (state == STOP) && tick && (tick_cnt == FULL_LAST);
  assign deliver     = stop_sample && sync2 && !par_bad;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_edge),
    .tick  (tick)
  );

  // Frame sequencing; busy and frame_err are updated with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      tick_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            busy     <= 1'b1;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= 3'd0;
              if (!sync2) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {sync2, shift[7:1]};
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (sync2) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start can arm.
          if (sync2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register with handshake and overrun detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_PARITY_EN
  logic parity_bit;
  logic par_sample;

  assign par_sample = (state == PARITY) && tick && (tick_cnt == FULL_LAST);
  assign par_bad    = parity_bit ^ (^shift);

  // Even-parity capture; the error is reported together with the stop result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (par_sample) begin
        parity_bit <= sync2;
      end
      if (stop_sample && par_bad) begin
        parity_err <= 1'b1;
      end
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule
